// File: rtl/sd_block_responder_if.sv
// Bundle of the sd_rd/sd_wr/sd_ack requester protocol and the byte-wide backing-store port.
// slave = block responder, master = requesters plus memory.
interface sd_block_responder_if #(
  parameter int NUM_CH = 3,
  parameter int LBA_W  = 32,
  parameter int MEM_AW = 32
);
  logic [NUM_CH-1:0]       sd_rd;
  logic [NUM_CH-1:0]       sd_wr;
  logic [NUM_CH*LBA_W-1:0] sd_lba_flat;
  logic [NUM_CH-1:0]       sd_ack;
  logic [8:0]              sd_buff_addr;
  logic [7:0]              sd_buff_dout;
  logic                    sd_buff_wr;
  logic [NUM_CH*8-1:0]     sd_buff_din_fl;
  logic                    mem_req;
  logic                    mem_we;
  logic [MEM_AW-1:0]       mem_addr;
  logic [7:0]              mem_wdata;
  logic [7:0]              mem_rdata;
  logic                    mem_ack;
  logic                    busy;

  modport slave (
    input  sd_rd, sd_wr, sd_lba_flat, sd_buff_din_fl, mem_rdata, mem_ack,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output sd_rd, sd_wr, sd_lba_flat, sd_buff_din_fl, mem_rdata, mem_ack,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sd_block_responder.sv
// Fixed-priority target for the sd block protocol: moves one 512-byte block per grant
// between a byte-wide backing store and the granted requester's buffer.
module sd_block_responder #(
  parameter int NUM_CH = 3,
  parameter int LBA_W  = 32,
  parameter int MEM_AW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  sd_block_responder_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW   = (LBA_W + 9 > MEM_AW) ? LBA_W + 9 : MEM_AW;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_MEM = 3'd1;
  localparam logic [2:0] WR_BUF = 3'd2;
  localparam logic [2:0] WR_MEM = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic             rd;
    logic [LBA_W-1:0] lba;
  } grant_t;

  logic [2:0]                    state;
  logic [8:0]                    idx;
  grant_t                        gnt, req;
  logic                          req_vld;
  logic [2:0]                    vld_pipe;
  logic                          gap;
  logic [FW-1:0]                 addr_full;
  logic [NUM_CH-1:0][LBA_W-1:0]  lba_arr;
  logic [NUM_CH-1:0][7:0]        din_arr;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      assign lba_arr[c] = bus.sd_lba_flat[c*LBA_W +: LBA_W];
      assign din_arr[c] = bus.sd_buff_din_fl[c*8 +: 8];
    end
  endgenerate

  // Lowest active channel wins; a channel asserting both levels is served as a read.
  always_comb begin
    req_vld = 1'b0;
    req     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.sd_rd[i] | bus.sd_wr[i]) begin
        req_vld = 1'b1;
        req.ch  = CH_W'(i);
        req.rd  = bus.sd_rd[i];
        req.lba = lba_arr[i];
      end
    end
  end

  assign addr_full = FW'({gnt.lba, 9'b0}) + FW'(idx);
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      gnt              <= '0;
      vld_pipe         <= '0;
      gap              <= 1'b0;
      bus.sd_ack       <= '0;
      bus.sd_buff_addr <= '0;
      bus.sd_buff_dout <= '0;
      bus.sd_buff_wr   <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
    end else begin
      bus.sd_buff_wr <= 1'b0;
      case (state)
        IDLE: if (req_vld) begin
          gnt        <= req;
          idx        <= '0;
          bus.sd_ack <= NUM_CH'(1) << req.ch;
          if (req.rd) begin
            state <= RD_MEM;
          end else begin
            state            <= WR_BUF;
            bus.sd_buff_addr <= '0;
            vld_pipe         <= 3'b001;
          end
        end
        // Request is re-raised one idle cycle after each ack, so only one is ever in flight.
        RD_MEM: if (!bus.mem_req) begin
          bus.mem_req  <= 1'b1;
          bus.mem_we   <= 1'b0;
          bus.mem_addr <= addr_full[MEM_AW-1:0];
        end else if (bus.mem_ack) begin
          bus.mem_req      <= 1'b0;
          bus.sd_buff_addr <= idx;
          bus.sd_buff_dout <= bus.mem_rdata;
          bus.sd_buff_wr   <= 1'b1;
          if (idx == 9'd511) begin
            state <= DONE;
            gap   <= 1'b0;
          end else begin
            idx <= idx + 9'd1;
          end
        end
        // Requester buffer is a registered RAM; one extra cycle of margin before sampling.
        WR_BUF: begin
          vld_pipe <= {vld_pipe[1:0], 1'b0};
          if (vld_pipe[2]) begin
            bus.mem_wdata <= din_arr[gnt.ch];
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_full[MEM_AW-1:0];
            state         <= WR_MEM;
          end
        end
        WR_MEM: if (bus.mem_req && bus.mem_ack) begin
          bus.mem_req <= 1'b0;
          if (idx == 9'd511) begin
            state <= DONE;
            gap   <= 1'b0;
          end else begin
            idx              <= idx + 9'd1;
            bus.sd_buff_addr <= idx + 9'd1;
            vld_pipe         <= 3'b001;
            state            <= WR_BUF;
          end
        end
        // Ack stays up through the final buffer strobe, then a two-cycle gap with ack low.
        DONE: begin
          bus.sd_ack <= '0;
          gap        <= 1'b1;
          if (gap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_block_responder.sv
// Randomized bench for sd_block_responder: behavioural memory, requester buffers and
// protocol monitors, with block contents predicted from the LBA arithmetic.
module tb_sd_block_responder;
  localparam int NUM_CH = 3, LBA_W = 32, MEM_AW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  sd_block_responder_if #(.NUM_CH(NUM_CH), .LBA_W(LBA_W), .MEM_AW(MEM_AW)) bus ();
  sd_block_responder #(.NUM_CH(NUM_CH), .LBA_W(LBA_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  logic [7:0]        wbuf [NUM_CH][512];
  int                key_mode = 0;
  int                max_delay = 0;
  int                hold_after = 1 << 30;
  int                inject_req = 0;
  int                inject_done = 0;
  int                wait_cnt = 0;
  int                strobes = 0;
  int                viol = 0;
  logic [8:0]        st_addr [$];
  logic [7:0]        st_data [$];
  logic [NUM_CH-1:0] st_ack  [$];
  longint            rd_log  [$];
  longint            wr_alog [$];
  logic [7:0]        wr_dlog [$];
  logic              pend = 1'b0;
  logic [31:0]       pend_addr = '0;
  logic              pend_we = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (key_mode == 0) return a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Backing store: acks each request after a random 0..max_delay wait.
  always @(negedge clk) begin
    if (reset) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (inject_req != inject_done) begin
      bus.mem_ack = 1'b1;
      inject_done = inject_done + 1;
    end else if (bus.mem_req && strobes < hold_after) begin
      if (wait_cnt == 0) begin
        bus.mem_rdata = mem_byte(bus.mem_addr);
        bus.mem_ack   = 1'b1;
        wait_cnt      = $urandom_range(max_delay, 0);
      end else begin
        wait_cnt = wait_cnt - 1;
      end
    end
  end

  // Requester buffers behave as registered RAMs addressed by sd_buff_addr.
  always @(negedge clk)
    for (int c = 0; c < NUM_CH; c++) bus.sd_buff_din_fl[c*8 +: 8] = wbuf[c][bus.sd_buff_addr];

  always @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if ($countones(bus.sd_ack) > 1) viol <= viol + 1;
      if (pend && (!bus.mem_req || bus.mem_addr !== pend_addr || bus.mem_we !== pend_we))
        viol <= viol + 1;
      if (bus.sd_buff_wr) begin
        strobes <= strobes + 1;
        st_addr.push_back(bus.sd_buff_addr);
        st_data.push_back(bus.sd_buff_dout);
        st_ack.push_back(bus.sd_ack);
        if (bus.sd_ack == '0) viol <= viol + 1;
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (bus.mem_we) begin
          wr_alog.push_back(longint'(bus.mem_addr));
          wr_dlog.push_back(bus.mem_wdata);
        end else begin
          rd_log.push_back(longint'(bus.mem_addr));
        end
      end
      pend      <= bus.mem_req && !bus.mem_ack;
      pend_addr <= bus.mem_addr;
      pend_we   <= bus.mem_we;
    end
  end

  task automatic wait_ack_rise(input int ch, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (bus.sd_ack[ch]) ok = 1'b1;
    end
  endtask

  task automatic wait_ack_fall(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 12000 && !ok; n++) begin
      @(negedge clk);
      if (bus.sd_ack == '0) ok = 1'b1;
    end
  endtask

  task automatic do_xfer(input string nm, input int ch, input bit rd, input bit wr,
                         input logic [31:0] lba);
    bit ok;
    int err, sa0, r0, w0, ns, nr, nw;
    longint base, a;
    logic [NUM_CH-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    sa0 = st_addr.size(); r0 = rd_log.size(); w0 = wr_alog.size();
    @(negedge clk);
    bus.sd_lba_flat[ch*LBA_W +: LBA_W] = lba;
    bus.sd_rd[ch] = rd;
    bus.sd_wr[ch] = wr;
    wait_ack_rise(ch, ok);
    checks++;
    if (!ok || bus.sd_ack !== oh) $display("FAIL %s grant: got %b expected %b", nm, bus.sd_ack, oh);
    else passes++;
    bus.sd_rd[ch] = 1'b0;
    bus.sd_wr[ch] = 1'b0;
    wait_ack_fall(ok);
    checks++;
    if (!ok) $display("FAIL %s ack_fall: got timeout expected ack low", nm); else passes++;
    repeat (3) @(negedge clk);
    base = longint'(lba) * 512;
    ns = st_addr.size() - sa0; nr = rd_log.size() - r0; nw = wr_alog.size() - w0;
    if (rd) begin
      checks++;
      if (ns != 512) $display("FAIL %s strobe_count: got %0d expected 512", nm, ns); else passes++;
      err = 0;
      for (int i = 0; i < 512 && i < ns; i++) begin
        a = (base + i) % (64'd1 << 32);
        if (st_addr[sa0+i] !== 9'(i) || st_data[sa0+i] !== mem_byte(32'(a)) || st_ack[sa0+i] !== oh)
          err++;
      end
      checks++;
      if (err != 0) $display("FAIL %s strobe_data: got %0d bad expected 0", nm, err); else passes++;
      err = 0;
      for (int i = 0; i < 512; i++)
        if (i >= nr || rd_log[r0+i] != (base + i) % (64'd1 << 32)) err++;
      checks++;
      if (err != 0) $display("FAIL %s mem_rd_addr: got %0d bad expected 0", nm, err); else passes++;
      checks++;
      if (nw != 0) $display("FAIL %s no_mem_wr: got %0d expected 0", nm, nw); else passes++;
    end else begin
      checks++;
      if (nw != 512) $display("FAIL %s mem_wr_count: got %0d expected 512", nm, nw); else passes++;
      err = 0;
      for (int i = 0; i < 512; i++)
        if (i >= nw || wr_alog[w0+i] != (base + i) % (64'd1 << 32) || wr_dlog[w0+i] !== wbuf[ch][i])
          err++;
      checks++;
      if (err != 0) $display("FAIL %s mem_wr_data: got %0d bad expected 0", nm, err); else passes++;
      checks++;
      if (ns != 0) $display("FAIL %s no_buff_wr: got %0d expected 0", nm, ns); else passes++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.sd_ack, bus.sd_buff_addr, bus.sd_buff_dout, bus.sd_buff_wr, bus.mem_req, bus.mem_we,
         bus.mem_addr, bus.mem_wdata, bus.busy} !== '0)
      $display("FAIL reset_outputs: got ack=%b req=%b busy=%b expected all 0", bus.sd_ack, bus.mem_req, bus.busy);
    else passes++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy); else passes++;
  endtask

  task automatic test_priority();
    bit ok;
    int n, sa0, r0, c0, c1, err;
    sa0 = st_addr.size(); r0 = rd_log.size();
    @(negedge clk);
    bus.sd_lba_flat[0 +: LBA_W] = 32'd3;
    bus.sd_lba_flat[LBA_W +: LBA_W] = 32'd9;
    bus.sd_rd[1:0] = 2'b11;
    wait_ack_rise(0, ok);
    checks++;
    if (!ok || bus.sd_ack !== 3'b001) $display("FAIL prio_first: got %b expected 001", bus.sd_ack); else passes++;
    bus.sd_rd[0] = 1'b0;
    wait_ack_fall(ok);
    n = 0;
    while (!bus.sd_ack[1] && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 2 || bus.sd_ack !== 3'b010) $display("FAIL prio_gap: got %0d cycles ack=%b expected 2 ack=010", n, bus.sd_ack);
    else passes++;
    bus.sd_rd[1] = 1'b0;
    wait_ack_fall(ok);
    repeat (3) @(negedge clk);
    c0 = 0; c1 = 0;
    for (int i = sa0; i < st_addr.size(); i++) begin
      if (st_ack[i] == 3'b001) c0++;
      if (st_ack[i] == 3'b010) c1++;
    end
    checks++;
    if (c0 != 512 || c1 != 512) $display("FAIL prio_strobes: got %0d/%0d expected 512/512", c0, c1); else passes++;
    err = 0;
    for (int i = 0; i < 1024; i++)
      if (r0 + i >= rd_log.size() || rd_log[r0+i] != (i < 512 ? 3*512 + i : 9*512 + i - 512)) err++;
    checks++;
    if (err != 0) $display("FAIL prio_order: got %0d bad expected 0", err); else passes++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s0, n;
    hold_after = strobes + 100;
    @(negedge clk);
    bus.sd_lba_flat[0 +: LBA_W] = 32'd5;
    bus.sd_rd[0] = 1'b1;
    wait_ack_rise(0, ok);
    bus.sd_rd[0] = 1'b0;
    n = 0;
    while (!(strobes >= hold_after && bus.mem_req) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) $display("FAIL rst_mid_reach: got timeout expected idx 100 pending"); else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.sd_ack, bus.sd_buff_addr, bus.sd_buff_dout, bus.sd_buff_wr, bus.mem_req, bus.mem_we,
         bus.mem_addr, bus.mem_wdata, bus.busy} !== '0)
      $display("FAIL rst_mid_outputs: got ack=%b req=%b busy=%b expected all 0", bus.sd_ack, bus.mem_req, bus.busy);
    else passes++;
    reset = 1'b0;
    s0 = strobes;
    @(negedge clk);
    inject_req = inject_req + 1;
    repeat (5) @(negedge clk);
    checks++;
    if (strobes != s0) $display("FAIL rst_mid_late_ack: got %0d strobes expected %0d", strobes, s0); else passes++;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.sd_ack !== '0)
      $display("FAIL rst_mid_idle: got busy=%b req=%b expected 0 0", bus.busy, bus.mem_req);
    else passes++;
    hold_after = 1 << 30;
  endtask

  task automatic test_random_delay();
    int ch;
    bit rd;
    logic [31:0] lba;
    key_mode = 1;
    max_delay = 7;
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < 512; i++) wbuf[c][i] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      ch  = $urandom_range(NUM_CH - 1, 0);
      rd  = (k != 1);
      lba = (k == 0) ? 32'hFFFF_FFFF : $urandom;
      do_xfer($sformatf("rand%0d", k), ch, rd, !rd, lba);
    end
  endtask

  initial begin
    bus.sd_rd = '0;
    bus.sd_wr = '0;
    bus.sd_lba_flat = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < 512; i++) wbuf[c][i] = '0;
    test_reset();
    do_xfer("read_ch0", 0, 1'b1, 1'b0, 32'd2);
    for (int i = 0; i < 512; i++) wbuf[2][i] = ~8'(i);
    do_xfer("write_ch2", 2, 1'b0, 1'b1, 32'd1);
    test_priority();
    do_xfer("rd_wr_both", 0, 1'b1, 1'b1, 32'd7);
    test_reset_mid();
    test_random_delay();
    checks++;
    if (viol != 0) $display("FAIL protocol_monitor: got %0d violations expected 0", viol); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
